// File: rtl/uart8.sv
// Byte-wide UART transceiver: 8 data bits, no parity, 1 stop bit, LSB first.
// Independent TX and RX state machines share one bit-period timebase constant.
module uart8 #(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  logic       rx,
    input  logic       rxEn,
    output logic [7:0] out,
    output logic       rxDone,
    output logic       rxBusy,
    output logic       rxErr,
    output logic       tx,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] in,
    output logic       txDone,
    output logic       txBusy
);
    localparam int BIT = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = $clog2(BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_shr, tx_shr_n;
    logic          tx_done_q, tx_done_n;
    logic          tx_line;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shr    <= '0;
            tx_done_q <= 1'b0;
        end else begin
            tx_state  <= tx_state_n;
            tx_cnt    <= tx_cnt_n;
            tx_idx    <= tx_idx_n;
            tx_shr    <= tx_shr_n;
            tx_done_q <= tx_done_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shr_n   = tx_shr;
        tx_done_n  = 1'b0;
        tx_line    = 1'b1;
        if (tx_state != TX_IDLE) tx_cnt_n = tx_cnt + 1'b1;
        unique case (tx_state)
            TX_IDLE: begin
                if (txEn && txStart) begin
                    tx_state_n = TX_START;
                    tx_shr_n   = in;
                    tx_cnt_n   = '0;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                end
            end
            TX_DATA: begin
                tx_line = tx_shr[tx_idx];
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    tx_idx_n = tx_idx + 1'b1;
                    if (tx_idx == 3'd7) tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_IDLE;
                    tx_cnt_n   = '0;
                    tx_done_n  = 1'b1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        // Dropping the enable abandons the frame without a completion pulse.
        if (!txEn) begin
            tx_state_n = TX_IDLE;
            tx_cnt_n   = '0;
            tx_idx_n   = '0;
            tx_done_n  = 1'b0;
        end
    end

    // Gated by txEn so an abort releases the line in the same cycle.
    assign tx     = txEn ? tx_line : 1'b1;
    assign txBusy = txEn && (tx_state != TX_IDLE);
    assign txDone = tx_done_q;

    // ---------------- receiver ----------------
    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_shr, rx_shr_n;
    logic [7:0]    out_n;
    logic          rx_done_n, rx_err_n;
    logic          rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shr   <= '0;
            out      <= 8'h00;
            rxDone   <= 1'b0;
            rxErr    <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shr   <= rx_shr_n;
            out      <= out_n;
            rxDone   <= rx_done_n;
            rxErr    <= rx_err_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_shr_n   = rx_shr;
        out_n      = out;
        rx_done_n  = 1'b0;
        rx_err_n   = rxErr;
        if (rx_state != RX_IDLE) rx_cnt_n = rx_cnt + 1'b1;
        unique case (rx_state)
            RX_IDLE: begin
                // Needs a high-then-low pair, so a line stuck low never retriggers.
                if (rx_prev && !rx_s2) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    rx_shr_n = {rx_s2, rx_shr[7:1]};
                    rx_idx_n = rx_idx + 1'b1;
                    if (rx_idx == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    if (rx_s2) begin
                        out_n     = rx_shr;
                        rx_done_n = 1'b1;
                        rx_err_n  = 1'b0;
                    end else begin
                        rx_err_n  = 1'b1;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
        if (!rxEn) begin
            rx_state_n = RX_IDLE;
            rx_cnt_n   = '0;
            rx_idx_n   = '0;
            rx_done_n  = 1'b0;
            rx_err_n   = rxErr;
            out_n      = out;
        end
    end

    assign rxBusy = rxEn && (rx_state != RX_IDLE);

endmodule

// File: tb/tb_uart8.sv
// Bench for uart8 at BIT=10: TX frames checked cycle-by-cycle against a queue,
// RX results checked on each rxDone pulse, plus reset/error/enable scenarios.
module tb_uart8;
    localparam int CLOCK_RATE = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int BIT        = 10;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop_mode = 1'b0;
    logic       rx_line;
    logic       rxEn = 1'b0;
    logic       txEn = 1'b0;
    logic       txStart = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic [7:0] out;
    logic       rxDone, rxBusy, rxErr, tx, txDone, txBusy;

    always #5 clk = ~clk;

    assign rx_line = loop_mode ? tx : rx_drv;

    uart8 #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)) dut (
        .clk(clk), .rst_ni(rst_ni), .rx(rx_line), .rxEn(rxEn),
        .out(out), .rxDone(rxDone), .rxBusy(rxBusy), .rxErr(rxErr),
        .tx(tx), .txEn(txEn), .txStart(txStart), .in(tx_byte),
        .txDone(txDone), .txBusy(txBusy)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Free-running activity counters, cleared by individual scenarios.
    int rx_busy_cyc = 0;
    int tx_act_cyc = 0;
    int tx_done_total = 0;
    always @(negedge clk) begin
        rx_busy_cyc   += int'(rxBusy);
        tx_act_cyc    += int'((tx == 1'b0) || txBusy);
        tx_done_total += int'(txDone);
    end

    // TX line monitor: every cycle of a frame compared to the expected byte.
    logic       tx_mon_on = 1'b0;
    logic       tx_act = 1'b0;
    logic       tx_post = 1'b0;
    logic [9:0] tx_frame = '1;
    int tx_cyc = 0, tx_bad = 0, tx_busy_n = 0, tx_done_in = 0, tx_frames = 0;
    always @(negedge clk) begin
        if (!tx_mon_on) begin
            tx_act  = 1'b0;
            tx_post = 1'b0;
        end else if (tx_post) begin
            check_eq("tx_done_cycle", {txDone, txBusy, tx}, 3'b101);
            tx_post = 1'b0;
        end else if (!tx_act && tx === 1'b0) begin
            tx_frames++;
            if (tx_exp_q.size() == 0) begin
                check_eq("tx_unexpected_frame", tx_exp_q.size(), 1);
            end else begin
                tx_frame   = {1'b1, tx_exp_q.pop_front(), 1'b0};
                tx_act     = 1'b1;
                tx_cyc     = 0;
                tx_bad     = 0;
                tx_busy_n  = 0;
                tx_done_in = 0;
            end
        end
        if (tx_act) begin
            if (tx !== tx_frame[tx_cyc / BIT]) tx_bad++;
            if (txBusy) tx_busy_n++;
            if (txDone) tx_done_in++;
            tx_cyc++;
            if (tx_cyc == 10 * BIT) begin
                check_eq("tx_line_bad_cycles", tx_bad, 0);
                check_eq("tx_busy_len", tx_busy_n, 10 * BIT);
                check_eq("tx_done_in_frame", tx_done_in, 0);
                tx_act  = 1'b0;
                tx_post = 1'b1;
            end
        end
    end

    // RX scoreboard: pop on every rxDone pulse.
    int rx_done_n = 0;
    always @(negedge clk) begin
        if (rxDone === 1'b1) begin
            rx_done_n++;
            if (rx_exp_q.size() == 0) check_eq("rx_unexpected_done", rx_exp_q.size(), 1);
            else check_eq("rx_out", out, rx_exp_q.pop_front());
            check_eq("rx_err_on_done", rxErr, 0);
        end
    end

    task automatic send_tx(input logic [7:0] b, input logic expect_frame);
        tx_byte = b;
        if (expect_frame) tx_exp_q.push_back(b);
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (BIT) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * BIT) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq(tag, {tx, out, txBusy, txDone, rxDone, rxBusy, rxErr}, {1'b1, 8'h00, 5'b00000});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle
        repeat (3) @(negedge clk);
        check_reset_vals("reset_values");
        rst_ni = 1'b1;
        repeat (100) @(negedge clk);
        check_reset_vals("idle_values");

        // Single byte, ignored mid-frame request, back-to-back frame
        txEn = 1'b1;
        tx_mon_on = 1'b1;
        send_tx(8'hA5, 1'b1);
        repeat (30) @(negedge clk);
        send_tx(8'hFF, 1'b0);
        for (int i = 0; i < 200 && txDone !== 1'b1; i++) @(negedge clk);
        check_eq("a5_done_seen", txDone, 1);
        send_tx(8'h3C, 1'b1);
        check_eq("b2b_start", {txBusy, tx}, 2'b10);
        repeat (10 * BIT + 5) @(negedge clk);
        check_eq("tx_frames", tx_frames, 2);
        check_eq("tx_done_total", tx_done_total, 2);

        // Loopback
        loop_mode = 1'b1;
        rxEn = 1'b1;
        repeat (5) @(negedge clk);
        rx_exp_q.push_back(8'h3C);
        send_tx(8'h3C, 1'b1);
        repeat (11 * BIT) @(negedge clk);
        check_eq("loop_done_cnt", rx_done_n, 1);
        check_eq("loop_out", out, 8'h3C);
        check_eq("loop_err", rxErr, 0);
        loop_mode = 1'b0;
        repeat (5) @(negedge clk);

        // Framing error keeps the previous byte
        drive_rx(8'h99, 1'b0);
        check_eq("ferr_flag", rxErr, 1);
        check_eq("ferr_out_held", out, 8'h3C);
        check_eq("ferr_no_done", rx_done_n, 1);

        // Short glitch is rejected at the start-bit midpoint
        rx_busy_cyc = 0;
        rx_drv = 1'b0;
        repeat (BIT / 4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check_eq("glitch_busy_short", (rx_busy_cyc > 0) && (rx_busy_cyc <= BIT / 2 + 2), 1);
        check_eq("glitch_no_done", rx_done_n, 1);
        check_eq("glitch_err_kept", rxErr, 1);
        check_eq("glitch_idle", rxBusy, 0);

        // Valid frame clears the error
        rx_exp_q.push_back(8'h55);
        drive_rx(8'h55, 1'b1);
        check_eq("valid_done_cnt", rx_done_n, 2);
        check_eq("valid_err_clear", rxErr, 0);
        check_eq("valid_out", out, 8'h55);

        // Receiver disabled
        rxEn = 1'b0;
        rx_busy_cyc = 0;
        drive_rx(8'hAA, 1'b1);
        check_eq("rxen0_busy", rx_busy_cyc, 0);
        check_eq("rxen0_done", rx_done_n, 2);
        check_eq("rxen0_out", out, 8'h55);

        // Transmitter disabled
        txEn = 1'b0;
        tx_act_cyc = 0;
        send_tx(8'h77, 1'b0);
        repeat (3 * BIT) @(negedge clk);
        check_eq("txen0_activity", tx_act_cyc, 0);
        check_eq("txen0_frames", tx_frames, 3);

        // Abort by dropping txEn mid-frame
        tx_mon_on = 1'b0;
        txEn = 1'b1;
        tx_done_total = 0;
        send_tx(8'h00, 1'b0);
        repeat (24) @(negedge clk);
        check_eq("abort_pre", {txBusy, tx}, 2'b10);
        txEn = 1'b0;
        #1;
        check_eq("abort_now", {txBusy, tx}, 2'b01);
        repeat (2) @(negedge clk);
        txEn = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        check_eq("abort_no_done", tx_done_total, 0);
        check_eq("abort_idle", {txBusy, tx}, 2'b01);

        // Asynchronous reset in the middle of a looped-back frame
        loop_mode = 1'b1;
        rxEn = 1'b1;
        repeat (3) @(negedge clk);
        send_tx(8'h81, 1'b0);
        repeat (34) @(negedge clk);
        check_eq("rst_mid_pre", {txBusy, rxBusy}, 2'b11);
        rst_ni = 1'b0;
        #1;
        check_reset_vals("rst_mid_values");
        repeat (3) @(negedge clk);
        loop_mode = 1'b0;
        rst_ni = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        check_reset_vals("rst_mid_after");

        check_eq("tx_queue_empty", tx_exp_q.size(), 0);
        check_eq("rx_queue_empty", rx_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
